// File: rtl/sprite_motion_controller_pkg.sv
//==============================================================================
// Module      : sprite_pkg
// Description : Shared constants for the sprite motion controller: edge modes,
//               hit-bit indices and the default coordinate width.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sprite_pkg;

  localparam int DEF_CW = 10;

  typedef enum logic [1:0] {
    MODE_CLAMP  = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_RSVD   = 2'd3
  } edge_mode_e;

  localparam int HIT_LEFT   = 0;
  localparam int HIT_RIGHT  = 1;
  localparam int HIT_TOP    = 2;
  localparam int HIT_BOTTOM = 3;

endpackage

`default_nettype wire

// File: rtl/sprite_motion_controller_if.sv
//==============================================================================
// Module      : sprite_motion_controller_if
// Description : Control inputs and motion outputs of the sprite controller.
//               The master drives buttons/ticks/loads; the slave is the engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sprite_motion_controller_if
  import sprite_pkg::*;
#(
  parameter int CW = DEF_CW
);

  logic                 refresh_tick_i;
  logic                 enable_i;
  logic                 btn_up_i;
  logic                 btn_down_i;
  logic                 btn_left_i;
  logic                 btn_right_i;
  logic [1:0]           mode_i;
  logic                 load_i;
  logic [2*CW-1:0]      load_pos_i;
  logic [2*CW-1:0]      position_o;
  logic signed [CW-1:0] vel_x_o;
  logic signed [CW-1:0] vel_y_o;
  logic [3:0]           hit_edge_o;
  logic                 moving_o;

  modport master (
    output refresh_tick_i, enable_i, btn_up_i, btn_down_i, btn_left_i,
           btn_right_i, mode_i, load_i, load_pos_i,
    input  position_o, vel_x_o, vel_y_o, hit_edge_o, moving_o
  );

  modport slave (
    input  refresh_tick_i, enable_i, btn_up_i, btn_down_i, btn_left_i,
           btn_right_i, mode_i, load_i, load_pos_i,
    output position_o, vel_x_o, vel_y_o, hit_edge_o, moving_o
  );

endinterface

`default_nettype wire

// File: rtl/sprite_motion_controller_axis.sv
//==============================================================================
// Module      : axis_motion
// Description : One axis of sprite motion: velocity ramp/decay with a speed
//               cap, position advance and clamp/wrap/bounce edge handling.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_motion
  import sprite_pkg::*;
#(
  parameter int CW        = DEF_CW,
  parameter int LIM       = 610,
  parameter int INIT      = 300,
  parameter int ACCEL     = 1,
  parameter int DECEL     = 1,
  parameter int MAX_SPEED = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 tick_i,
  input  wire logic                 load_i,
  input  wire logic [CW-1:0]        load_val_i,
  input  wire logic signed [1:0]    dir_i,
  input  wire logic [1:0]           mode_i,
  output logic [CW-1:0]             pos_o,
  output logic signed [CW-1:0]      vel_o,
  output logic signed [CW-1:0]      vel_nxt_o,
  output logic                      hit_lo_o,
  output logic                      hit_hi_o
);

  // Two guard bits hold the sign plus one overflow bit of pos + vel.
  localparam int                  W       = CW + 2;
  localparam logic signed [W-1:0] c_lim   = W'(LIM);
  localparam logic signed [W-1:0] c_span  = W'(LIM + 1);
  localparam logic signed [W-1:0] c_acc   = W'(ACCEL);
  localparam logic signed [W-1:0] c_dec   = W'(DECEL);
  localparam logic signed [W-1:0] c_max   = W'(MAX_SPEED);
  localparam logic [CW-1:0]       c_lim_u = CW'(LIM);
  localparam logic [CW-1:0]       c_init  = CW'(INIT);

  logic [CW-1:0]        pos_q, pos_d;
  logic signed [CW-1:0] vel_q, vel_d;
  logic                 hit_lo_q, hit_lo_d, hit_hi_q, hit_hi_d;
  logic signed [W-1:0]  v_cur, v_step, p_cand;
  logic [CW-1:0]        p_fix;
  logic signed [CW-1:0] v_fix;
  logic                 cross_lo, cross_hi;

  // Velocity step: accelerate toward the held direction or decay toward zero.
  always_comb begin
    v_cur  = {{2{vel_q[CW-1]}}, vel_q};
    v_step = v_cur;
    case (dir_i)
      2'b01:   v_step = (v_cur + c_acc > c_max) ? c_max : v_cur + c_acc;
      2'b11:   v_step = (v_cur - c_acc < -c_max) ? -c_max : v_cur - c_acc;
      default: begin
        if (v_cur > c_dec)       v_step = v_cur - c_dec;
        else if (v_cur < -c_dec) v_step = v_cur + c_dec;
        else                     v_step = '0;
      end
    endcase
  end

  // Candidate position and edge resolution; reserved mode behaves as clamp.
  always_comb begin
    p_cand   = $signed({2'b00, pos_q}) + v_step;
    cross_lo = p_cand[W-1];
    cross_hi = !p_cand[W-1] && (p_cand > c_lim);
    p_fix    = CW'(p_cand);
    v_fix    = CW'(v_step);
    case (edge_mode_e'(mode_i))
      MODE_WRAP: begin
        if (cross_lo)      p_fix = CW'(p_cand + c_span);
        else if (cross_hi) p_fix = CW'(p_cand - c_span);
      end
      MODE_BOUNCE: begin
        if (cross_lo) begin
          p_fix = CW'(-p_cand);
          v_fix = CW'(-v_step);
        end else if (cross_hi) begin
          p_fix = CW'(c_lim + c_lim - p_cand);
          v_fix = CW'(-v_step);
        end
      end
      default: begin
        if (cross_lo) begin
          p_fix = '0;
          v_fix = '0;
        end else if (cross_hi) begin
          p_fix = c_lim_u;
          v_fix = '0;
        end
      end
    endcase
  end

  // Next state: load beats tick; hit flags are single-cycle pulses.
  always_comb begin
    pos_d    = pos_q;
    vel_d    = vel_q;
    hit_lo_d = 1'b0;
    hit_hi_d = 1'b0;
    if (load_i) begin
      pos_d = (load_val_i > c_lim_u) ? c_lim_u : load_val_i;
      vel_d = '0;
    end else if (tick_i) begin
      pos_d    = p_fix;
      vel_d    = v_fix;
      hit_lo_d = cross_lo;
      hit_hi_d = cross_hi;
    end
  end

  // Axis state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q    <= c_init;
      vel_q    <= '0;
      hit_lo_q <= 1'b0;
      hit_hi_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      vel_q    <= vel_d;
      hit_lo_q <= hit_lo_d;
      hit_hi_q <= hit_hi_d;
    end
  end

  assign pos_o     = pos_q;
  assign vel_o     = vel_q;
  assign vel_nxt_o = vel_d;
  assign hit_lo_o  = hit_lo_q;
  assign hit_hi_o  = hit_hi_q;

endmodule

`default_nettype wire

// File: rtl/sprite_motion_controller.sv
//==============================================================================
// Module      : sprite_motion_controller
// Description : Frame-tick driven motion engine for one rectangular sprite.
//               Decodes buttons, runs one axis_motion per axis, packs outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sprite_motion_controller
  import sprite_pkg::*;
#(
  parameter int CW        = DEF_CW,
  parameter int X_MAX     = 640,
  parameter int Y_MAX     = 480,
  parameter int SIZE_X    = 30,
  parameter int SIZE_Y    = 30,
  parameter int INIT_X    = 300,
  parameter int INIT_Y    = 220,
  parameter int ACCEL     = 1,
  parameter int DECEL     = 1,
  parameter int MAX_SPEED = 8
) (
  input  wire logic clk,
  input  wire logic rst_n,
  sprite_motion_controller_if.slave bus
);

  logic signed [1:0]    dir_x, dir_y;
  logic                 tick;
  logic [CW-1:0]        pos_x, pos_y;
  logic signed [CW-1:0] vx_nxt, vy_nxt;
  logic                 hit_l, hit_r, hit_t, hit_b;
  logic                 moving_q;

  // Button decode: opposing buttons cancel to "no direction".
  always_comb begin
    dir_x = 2'b00;
    dir_y = 2'b00;
    if (bus.btn_right_i && !bus.btn_left_i)      dir_x = 2'b01;
    else if (bus.btn_left_i && !bus.btn_right_i) dir_x = 2'b11;
    if (bus.btn_down_i && !bus.btn_up_i)         dir_y = 2'b01;
    else if (bus.btn_up_i && !bus.btn_down_i)    dir_y = 2'b11;
  end

  assign tick = bus.refresh_tick_i && bus.enable_i;

  axis_motion #(
    .CW(CW), .LIM(X_MAX - SIZE_X), .INIT(INIT_X),
    .ACCEL(ACCEL), .DECEL(DECEL), .MAX_SPEED(MAX_SPEED)
  ) u_axis_x (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .load_i(bus.load_i),
    .load_val_i(bus.load_pos_i[CW-1:0]), .dir_i(dir_x), .mode_i(bus.mode_i),
    .pos_o(pos_x), .vel_o(bus.vel_x_o), .vel_nxt_o(vx_nxt),
    .hit_lo_o(hit_l), .hit_hi_o(hit_r)
  );

  axis_motion #(
    .CW(CW), .LIM(Y_MAX - SIZE_Y), .INIT(INIT_Y),
    .ACCEL(ACCEL), .DECEL(DECEL), .MAX_SPEED(MAX_SPEED)
  ) u_axis_y (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .load_i(bus.load_i),
    .load_val_i(bus.load_pos_i[2*CW-1:CW]), .dir_i(dir_y), .mode_i(bus.mode_i),
    .pos_o(pos_y), .vel_o(bus.vel_y_o), .vel_nxt_o(vy_nxt),
    .hit_lo_o(hit_t), .hit_hi_o(hit_b)
  );

  // Moving flag tracks the velocities that are about to be registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) moving_q <= 1'b0;
    else        moving_q <= (vx_nxt != '0) || (vy_nxt != '0);
  end

  // Output packing.
  always_comb begin
    bus.hit_edge_o             = '0;
    bus.hit_edge_o[HIT_LEFT]   = hit_l;
    bus.hit_edge_o[HIT_RIGHT]  = hit_r;
    bus.hit_edge_o[HIT_TOP]    = hit_t;
    bus.hit_edge_o[HIT_BOTTOM] = hit_b;
  end

  assign bus.position_o = {pos_y, pos_x};
  assign bus.moving_o   = moving_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_motion_controller.sv
//==============================================================================
// Module      : tb_sprite_motion_controller
// Description : Directed scoreboard bench for the sprite motion controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sprite_motion_controller;

  logic clk;
  logic rst_n;

  sprite_motion_controller_if #(.CW(10)) bus ();

  sprite_motion_controller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    string                tag;
    logic [9:0]           x;
    logic [9:0]           y;
    logic signed [9:0]    vx;
    logic signed [9:0]    vy;
    logic [3:0]           hit;
    logic                 mv;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input int x, input int y, input int vx,
                      input int vy, input logic [3:0] hit, input logic mv);
    exp_t e;
    e.tag = tag;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.vx  = 10'(vx);
    e.vy  = 10'(vy);
    e.hit = hit;
    e.mv  = mv;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1 entries");
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checks++;
    assert (bus.position_o[9:0] === e.x) else begin
      errors++;
      $error("FAIL %s.x observed=%0d expected=%0d", e.tag, bus.position_o[9:0], e.x);
    end
    checks++;
    assert (bus.position_o[19:10] === e.y) else begin
      errors++;
      $error("FAIL %s.y observed=%0d expected=%0d", e.tag, bus.position_o[19:10], e.y);
    end
    checks++;
    assert (bus.vel_x_o === e.vx) else begin
      errors++;
      $error("FAIL %s.vx observed=%0d expected=%0d", e.tag, bus.vel_x_o, e.vx);
    end
    checks++;
    assert (bus.vel_y_o === e.vy) else begin
      errors++;
      $error("FAIL %s.vy observed=%0d expected=%0d", e.tag, bus.vel_y_o, e.vy);
    end
    checks++;
    assert (bus.hit_edge_o === e.hit) else begin
      errors++;
      $error("FAIL %s.hit observed=%b expected=%b", e.tag, bus.hit_edge_o, e.hit);
    end
    checks++;
    assert (bus.moving_o === e.mv) else begin
      errors++;
      $error("FAIL %s.moving observed=%b expected=%b", e.tag, bus.moving_o, e.mv);
    end
  endtask

  // One clock with an optional frame tick; load strobe is one-shot.
  task automatic clk_step(input bit tick);
    @(negedge clk);
    bus.refresh_tick_i = tick;
    @(posedge clk);
    #1;
    bus.refresh_tick_i = 1'b0;
    bus.load_i         = 1'b0;
    check_out();
  endtask

  task automatic do_load(input string tag, input int lx, input int ly,
                         input int ex, input int ey, input bit with_tick);
    bus.load_i     = 1'b1;
    bus.load_pos_i = {10'(ly), 10'(lx)};
    push(tag, ex, ey, 0, 0, 4'b0000, 1'b0);
    clk_step(with_tick);
  endtask

  initial begin
    int x;
    int vx;

    rst_n              = 1'b0;
    bus.refresh_tick_i = 1'b0;
    bus.enable_i       = 1'b1;
    bus.btn_up_i       = 1'b0;
    bus.btn_down_i     = 1'b0;
    bus.btn_left_i     = 1'b0;
    bus.btn_right_i    = 1'b0;
    bus.mode_i         = 2'd0;
    bus.load_i         = 1'b0;
    bus.load_pos_i     = '0;

    // Reset values, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    push("reset_hold", 300, 220, 0, 0, 4'b0000, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    push("reset_rel", 300, 220, 0, 0, 4'b0000, 1'b0);
    clk_step(1'b1);

    // Clamp, ramp right for 10 ticks then coast to a stop.
    bus.btn_right_i = 1'b1;
    x = 300;
    for (int i = 1; i <= 10; i++) begin
      vx = (i > 8) ? 8 : i;
      x += vx;
      push("ramp", x, 220, vx, 0, 4'b0000, 1'b1);
      clk_step(1'b1);
    end
    bus.btn_right_i = 1'b0;
    for (int v = 7; v >= 0; v--) begin
      x += v;
      push("coast", x, 220, v, 0, 4'b0000, v != 0);
      clk_step(1'b1);
    end

    // Asynchronous reset while moving.
    bus.btn_right_i = 1'b1;
    push("mv1", 381, 220, 1, 0, 4'b0000, 1'b1);
    clk_step(1'b1);
    push("mv2", 383, 220, 2, 0, 4'b0000, 1'b1);
    clk_step(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", 300, 220, 0, 0, 4'b0000, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    bus.btn_right_i = 1'b0;

    // Load saturation to the legal range.
    do_load("load_sat", 1000, 500, 610, 450, 1'b0);

    // Clamp at the right edge.
    do_load("load_600", 600, 220, 600, 220, 1'b0);
    bus.btn_right_i = 1'b1;
    push("cl1", 601, 220, 1, 0, 4'b0000, 1'b1); clk_step(1'b1);
    push("cl2", 603, 220, 2, 0, 4'b0000, 1'b1); clk_step(1'b1);
    push("cl3", 606, 220, 3, 0, 4'b0000, 1'b1); clk_step(1'b1);
    push("cl_eq_lim", 610, 220, 4, 0, 4'b0000, 1'b1); clk_step(1'b1);
    push("cl_hit", 610, 220, 0, 0, 4'b0010, 1'b0); clk_step(1'b1);
    push("cl_pulse_end", 610, 220, 0, 0, 4'b0000, 1'b0); clk_step(1'b0);

    // Wrap at the right edge.
    bus.mode_i = 2'd1;
    do_load("load_608", 608, 220, 608, 220, 1'b0);
    push("wr1", 609, 220, 1, 0, 4'b0000, 1'b1); clk_step(1'b1);
    push("wr_hit", 0, 220, 2, 0, 4'b0010, 1'b1); clk_step(1'b1);
    push("wr_pulse_end", 0, 220, 2, 0, 4'b0000, 1'b1); clk_step(1'b0);
    bus.btn_right_i = 1'b0;

    // Bounce off the top.
    bus.mode_i = 2'd2;
    do_load("load_y2", 300, 2, 300, 2, 1'b0);
    bus.btn_up_i = 1'b1;
    push("bo1", 300, 1, 0, -1, 4'b0000, 1'b1); clk_step(1'b1);
    push("bo_hit", 300, 1, 0, 2, 4'b0100, 1'b1); clk_step(1'b1);
    push("bo3", 300, 2, 0, 1, 4'b0000, 1'b1); clk_step(1'b1);

    // Load coincident with a tick takes the load.
    do_load("load_vs_tick", 50, 100, 50, 100, 1'b1);
    bus.btn_up_i = 1'b0;

    // Enable low freezes motion; resumes from the held velocity.
    bus.mode_i = 2'd0;
    bus.btn_right_i = 1'b1;
    push("en1", 51, 100, 1, 0, 4'b0000, 1'b1); clk_step(1'b1);
    push("en2", 53, 100, 2, 0, 4'b0000, 1'b1); clk_step(1'b1);
    bus.enable_i = 1'b0;
    bus.btn_down_i = 1'b1;
    push("dis1", 53, 100, 2, 0, 4'b0000, 1'b1); clk_step(1'b1);
    push("dis2", 53, 100, 2, 0, 4'b0000, 1'b1); clk_step(1'b1);
    bus.enable_i = 1'b1;
    bus.btn_down_i = 1'b0;

    // Both horizontal buttons held: decay only.
    bus.btn_left_i = 1'b1;
    push("both1", 54, 100, 1, 0, 4'b0000, 1'b1); clk_step(1'b1);
    push("both2", 54, 100, 0, 0, 4'b0000, 1'b0); clk_step(1'b1);
    bus.btn_right_i = 1'b0;

    // Reserved mode behaves as clamp at the left edge; exactly 0 is no hit.
    bus.mode_i = 2'd3;
    do_load("load_x1", 1, 100, 1, 100, 1'b0);
    push("rs_eq0", 0, 100, -1, 0, 4'b0000, 1'b1); clk_step(1'b1);
    push("rs_hit", 0, 100, 0, 0, 4'b0001, 1'b0); clk_step(1'b1);
    bus.btn_left_i = 1'b0;

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_motion_controller.md
Name: sprite_motion_controller

Overview:
- Parametrised motion engine for one on-screen rectangular sprite. It is the successor of the fixed-step square mover.
- Adds per-axis velocity with acceleration, deceleration and a speed cap, plus three edge modes: clamp, wrap and bounce.
- Adds synchronous position load and one-tick edge-hit pulses.
- Sits between the debounced buttons and the pixel generator. It advances only on the frame refresh tick.

Parameters:
- CW, 10: coordinate width in bits, per axis.
- X_MAX, 640: display width in pixels.
- Y_MAX, 480: display height in pixels.
- SIZE_X, 30: sprite width in pixels.
- SIZE_Y, 30: sprite height in pixels.
- INIT_X, 300: reset x coordinate.
- INIT_Y, 220: reset y coordinate.
- ACCEL, 1: velocity change per tick while a direction is held.
- DECEL, 1: velocity decay per tick when no direction (or both) is held.
- MAX_SPEED, 8: velocity magnitude cap. Must be ≤ X_MAX-SIZE_X and ≤ Y_MAX-SIZE_Y.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- refresh_tick  in  1  one-clk pulse per frame.
- enable  in  1  motion enable; ticks are ignored when low.
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced direction buttons.
- mode  in  2  edge mode: 0 clamp, 1 wrap, 2 bounce, 3 reserved (treated as clamp).
- load  in  1  synchronous position load strobe.
- load_pos  in  2*CW  {y,x} position to load.
- position  out  2*CW  registered {y,x} top-left corner of the sprite.
- vel_x, vel_y  out  CW signed  current velocity per axis.
- hit_edge  out  4  one-clk pulses: [0] left, [1] right, [2] top, [3] bottom.
- moving  out  1  high when vel_x≠0 or vel_y≠0.

Behaviour:
- Reset (reset=0, asynchronous): position={INIT_Y,INIT_X}, vel_x=vel_y=0, hit_edge=0, moving=0.
- Limits: LIM_X=X_MAX-SIZE_X, LIM_Y=Y_MAX-SIZE_Y. The legal coordinate range is 0..LIM per axis.
- Priority per clk: reset > load > (refresh_tick & enable) > hold.
- Load:
  - position <= load_pos, each axis saturated to 0..LIM.
  - Velocities cleared, hit_edge=0.
  - Load wins over a coincident tick.
- Tick (refresh_tick=1, enable=1): both axes update in parallel, all results registered. Latency is 1 clk; hit_edge is aligned with the new position.
- Direction per axis:
  - x: btn_right only = +1, btn_left only = -1, both or neither = 0.
  - y: btn_down only = +1, btn_up only = -1, otherwise 0.
- Velocity step:
  - dir≠0: v' = v + dir·ACCEL, saturated to ±MAX_SPEED.
  - dir=0: |v| reduced by DECEL toward 0, never crossing 0.
- Candidate position: p' = p + v', computed in signed CW+2 bits.
- Edge handling, clamp mode:
  - p'<0 gives p=0, v=0, low-side hit.
  - p'>LIM gives p=LIM, v=0, high-side hit.
  - p'==0 or p'==LIM exactly is not a hit.
- Edge handling, wrap mode:
  - p'<0 gives p=p'+LIM+1, low-side hit.
  - p'>LIM gives p=p'-(LIM+1), high-side hit.
  - Velocity is kept.
- Edge handling, bounce mode:
  - p'<0 gives p=-p', v=-v', low-side hit.
  - p'>LIM gives p=2·LIM-p', v=-v', high-side hit.
- hit_edge: asserted for exactly the one clk following a tick with a crossing; 0 otherwise. Both axes may hit in the same tick.
- enable=0: ticks are ignored; position and velocity are held. Motion resumes from the held velocity.
- mode changes take effect at the next tick.
- moving is registered and updated alongside the velocities.
- Reset mid-motion clears everything immediately, without waiting for clk.

Decomposition:
- Shared package `sprite_pkg`:
  - Mode constants: MODE_CLAMP=0, MODE_WRAP=1, MODE_BOUNCE=2.
  - Hit-bit index constants.
  - Default CW.
- Sub-module `axis_motion`, instantiated twice (x, y):
  - Parameters: CW, LIM, INIT, ACCEL, DECEL, MAX_SPEED.
  - Inputs: dir, tick, load, load value, mode.
  - Outputs: pos, vel, hit_lo, hit_hi.
  - The top level does button decode, packing and moving.

Test Plan:
1. Reset, then release reset → position={220,300}, vel 0, hit_edge=0; an asynchronous assert mid-motion returns these values with no clk edge.
2. Clamp mode, btn_right held 10 ticks → vel_x 1..8,8,8 and x=352. Then release → vel_x 7,6,…,0 over 8 ticks, moving falls on the last.
3. Clamp mode, load x=600, btn_right held:
   - x=601,603,606,610 with no hit on reaching 610.
   - Next tick: x=610, vel_x=0, hit_edge[1] for one clk.
4. Wrap mode, load x=608, btn_right held → x=609, then x=0 with hit_edge[1] pulsed and vel_x=2 retained.
5. Bounce mode, load y=2, btn_up held → y=1; next tick y=1, vel_y=+2, hit_edge[2]; next tick vel_y=+1, y=2.
6. Control priority:
   - load with refresh_tick in the same clk → load value taken, vel 0.
   - enable=0 with ticks and buttons → no change.
   - btn_left+btn_right together → decel only.
